// File: rtl/vga_plot_arbiter_pkg.sv
// Shared game constants and the plot arbiter FSM state encoding.
package vga_plot_arbiter_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StPlot,
    StDone
  } state_e;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Requester bus plus VGA pixel-write port of the plot arbiter.
interface vga_plot_arbiter_if #(
  parameter int unsigned NUM_REQ = 3
) ();

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_x;
  logic [7*NUM_REQ-1:0] req_y;
  logic [4*NUM_REQ-1:0] req_w_m1;
  logic [4*NUM_REQ-1:0] req_h_m1;
  logic [3*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 busy;
  logic [7:0]           oX;
  logic [6:0]           oY;
  logic [2:0]           oColour;
  logic                 oPlot;

  // Requester / VGA-adapter side.
  modport master (
    output req, req_x, req_y, req_w_m1, req_h_m1, req_colour,
    input  grant, done, busy, oX, oY, oColour, oPlot
  );

  // Arbiter side.
  modport slave (
    input  req, req_x, req_y, req_w_m1, req_h_m1, req_colour,
    output grant, done, busy, oX, oY, oColour, oPlot
  );

endinterface

// File: rtl/vga_plot_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module vga_plot_arbiter_rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan from farthest offset down so the nearest hit is written last and wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = IDX_W'((32'(i_rr_ptr) + (NUM_REQ - 1 - i)) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA pixel port; walks the winner's rectangle one pixel per clock.
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned X_SCREEN_PIXELS = SCREEN_W,
  parameter int unsigned Y_SCREEN_PIXELS = SCREEN_H
) (
  input logic              iClock,
  input logic              reset,
  vga_plot_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [7:0]         r_x, w_x_next;
  logic [6:0]         r_y, w_y_next;
  logic [3:0]         r_w_m1, w_w_m1_next;
  logic [3:0]         r_h_m1, w_h_m1_next;
  logic [2:0]         r_colour, w_colour_next;
  logic [3:0]         r_cx, w_cx_next;
  logic [3:0]         r_cy, w_cy_next;
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [NUM_REQ-1:0] r_done, w_done_next;
  logic               r_busy, w_busy_next;
  logic [7:0]         r_ox, w_ox_next;
  logic [6:0]         r_oy, w_oy_next;
  logic [2:0]         r_ocolour, w_ocolour_next;
  logic               r_oplot, w_oplot_next;

  logic               w_pick_valid;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [7:0]         w_sel_x;
  logic [6:0]         w_sel_y;
  logic [3:0]         w_sel_w_m1, w_sel_h_m1;
  logic [2:0]         w_sel_colour;
  logic [8:0]         w_px;
  logic [7:0]         w_py;

  vga_plot_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_pick_valid),
    .o_idx    (w_pick_idx)
  );

  always_comb begin
    w_sel_x      = '0;
    w_sel_y      = '0;
    w_sel_w_m1   = '0;
    w_sel_h_m1   = '0;
    w_sel_colour = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel_x      = bus.req_x[8*i +: 8];
        w_sel_y      = bus.req_y[7*i +: 7];
        w_sel_w_m1   = bus.req_w_m1[4*i +: 4];
        w_sel_h_m1   = bus.req_h_m1[4*i +: 4];
        w_sel_colour = bus.req_colour[3*i +: 3];
      end
    end
  end

  // Extra bit so off-screen sums are not wrapped back onto the screen.
  assign w_px = {1'b0, r_x} + {5'b0, r_cx};
  assign w_py = {1'b0, r_y} + {4'b0, r_cy};

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_rr_ptr_next  = r_rr_ptr;
    w_x_next       = r_x;
    w_y_next       = r_y;
    w_w_m1_next    = r_w_m1;
    w_h_m1_next    = r_h_m1;
    w_colour_next  = r_colour;
    w_cx_next      = r_cx;
    w_cy_next      = r_cy;
    w_grant_next   = r_grant;
    w_done_next    = '0;
    w_ox_next      = r_ox;
    w_oy_next      = r_oy;
    w_ocolour_next = r_ocolour;
    w_oplot_next   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_idx_next    = w_pick_idx;
          w_x_next      = w_sel_x;
          w_y_next      = w_sel_y;
          w_w_m1_next   = w_sel_w_m1;
          w_h_m1_next   = w_sel_h_m1;
          w_colour_next = w_sel_colour;
          w_grant_next  = NUM_REQ'(1) << w_pick_idx;
          w_state_next  = StGrant;
        end
      end
      StGrant: begin
        w_cx_next    = '0;
        w_cy_next    = '0;
        w_state_next = StPlot;
      end
      StPlot: begin
        w_ox_next      = w_px[7:0];
        w_oy_next      = w_py[6:0];
        w_ocolour_next = r_colour;
        w_oplot_next   = (32'(w_px) < X_SCREEN_PIXELS) && (32'(w_py) < Y_SCREEN_PIXELS);
        if (r_cx == r_w_m1) begin
          w_cx_next = '0;
          if (r_cy == r_h_m1) begin
            w_state_next = StDone;
          end else begin
            w_cy_next = r_cy + 4'd1;
          end
        end else begin
          w_cx_next = r_cx + 4'd1;
        end
      end
      StDone: begin
        w_done_next   = NUM_REQ'(1) << r_idx;
        w_grant_next  = '0;
        w_rr_ptr_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        w_state_next  = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    w_busy_next = (w_state_next != StIdle);
  end

  always_ff @(posedge iClock) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_rr_ptr  <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_w_m1    <= '0;
      r_h_m1    <= '0;
      r_colour  <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_ox      <= '0;
      r_oy      <= '0;
      r_ocolour <= '0;
      r_oplot   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_rr_ptr  <= w_rr_ptr_next;
      r_x       <= w_x_next;
      r_y       <= w_y_next;
      r_w_m1    <= w_w_m1_next;
      r_h_m1    <= w_h_m1_next;
      r_colour  <= w_colour_next;
      r_cx      <= w_cx_next;
      r_cy      <= w_cy_next;
      r_grant   <= w_grant_next;
      r_done    <= w_done_next;
      r_busy    <= w_busy_next;
      r_ox      <= w_ox_next;
      r_oy      <= w_oy_next;
      r_ocolour <= w_ocolour_next;
      r_oplot   <= w_oplot_next;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;
  assign bus.oX      = r_ox;
  assign bus.oY      = r_oy;
  assign bus.oColour = r_ocolour;
  assign bus.oPlot   = r_oplot;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: grant/pixel/done timing, round-robin, clipping, reset abort.
module tb_vga_plot_arbiter;
  import vga_plot_arbiter_pkg::*;

  logic iClock = 1'b0;
  logic reset  = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  vga_plot_arbiter_if #(.NUM_REQ(3)) bus ();

  vga_plot_arbiter #(
    .NUM_REQ         (3),
    .X_SCREEN_PIXELS (160),
    .Y_SCREEN_PIXELS (120)
  ) dut (
    .iClock (iClock),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 iClock = ~iClock;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_rect(input int k, input int x, input int y, input int wm1, input int hm1,
                          input logic [2:0] col);
    bus.req_x[8*k +: 8]      = 8'(x);
    bus.req_y[7*k +: 7]      = 7'(y);
    bus.req_w_m1[4*k +: 4]   = 4'(wm1);
    bus.req_h_m1[4*k +: 4]   = 4'(hm1);
    bus.req_colour[3*k +: 3] = col;
  endtask

  // Expects the next edge to grant requester k; walks the whole rectangle and its done pulse.
  task automatic run_rect(input int k, input int x, input int y, input int wm1, input int hm1,
                          input logic [2:0] col, input int exp_plots, input bit mutate,
                          input bit drop);
    int nplot;
    int ex;
    int ey;
    nplot = 0;
    tick();
    check("grant", 32'(bus.grant), 32'(1) << k);
    check("busy_grant", 32'(bus.busy), 1);
    check("done_at_grant", 32'(bus.done), 0);
    tick();
    check("oplot_grant_state", 32'(bus.oPlot), 0);
    for (int cy = 0; cy <= hm1; cy++) begin
      for (int cx = 0; cx <= wm1; cx++) begin
        if (mutate && cy == 0 && cx == 1) bus.req_x[8*k +: 8] = 8'd60;
        tick();
        ex = x + cx;
        ey = y + cy;
        check("oplot", 32'(bus.oPlot), ((ex < 160) && (ey < 120)) ? 1 : 0);
        check("ox", 32'(bus.oX), 32'(ex[7:0]));
        check("oy", 32'(bus.oY), 32'(ey[6:0]));
        check("ocolour", 32'(bus.oColour), 32'(col));
        check("done_walk", 32'(bus.done), 0);
        nplot += int'(bus.oPlot);
      end
    end
    check("plot_count", 32'(nplot), 32'(exp_plots));
    tick();
    check("done", 32'(bus.done), 32'(1) << k);
    check("grant_cleared", 32'(bus.grant), 0);
    check("busy_done", 32'(bus.busy), 0);
    check("oplot_done", 32'(bus.oPlot), 0);
    if (drop) bus.req[k] = 1'b0;
  endtask

  initial begin
    bus.req        = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_w_m1   = '0;
    bus.req_h_m1   = '0;
    bus.req_colour = '0;

    // Reset state
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ox", 32'(bus.oX), 0);
    check("rst_oy", 32'(bus.oY), 0);
    check("rst_ocolour", 32'(bus.oColour), 0);
    check("rst_oplot", 32'(bus.oPlot), 0);

    // Single request, 4x4 at (22,88); done lands W*H+2 = 18 edges after grant
    set_rect(1, 22, 88, 3, 3, RED);
    bus.req = 3'b010;
    run_rect(1, 22, 88, 3, 3, RED, 16, 1'b0, 1'b1);
    tick();
    check("done_single_pulse", 32'(bus.done), 0);
    check("idle_busy", 32'(bus.busy), 0);

    // rr_ptr is now 2: requester 2 is granted, then reset lands on its fifth pixel
    set_rect(2, 10, 20, 3, 3, 3'b010);
    bus.req = 3'b100;
    tick();
    check("rst_test_grant", 32'(bus.grant), 3'b100);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_test_oplot", 32'(bus.oPlot), 1);
      check("rst_test_ox", 32'(bus.oX), 32'(10 + i));
    end
    reset   = 1'b0;
    bus.req = '0;
    tick();
    check("abort_grant", 32'(bus.grant), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_ox", 32'(bus.oX), 0);
    check("abort_oy", 32'(bus.oY), 0);
    check("abort_ocolour", 32'(bus.oColour), 0);
    check("abort_oplot", 32'(bus.oPlot), 0);
    reset = 1'b1;
    tick();
    check("post_abort_done", 32'(bus.done), 0);
    check("post_abort_busy", 32'(bus.busy), 0);

    // rr_ptr back at 0: requester 0 (1x1 at origin) beats requester 2
    set_rect(0, 0, 0, 0, 0, 3'b011);
    set_rect(2, 158, 118, 3, 3, 3'b101);
    bus.req = 3'b101;
    run_rect(0, 0, 0, 0, 0, 3'b011, 1, 1'b0, 1'b1);

    // Clipped 4x4 at (158,118): four visible pixels, sixteen walked
    run_rect(2, 158, 118, 3, 3, 3'b101, 4, 1'b0, 1'b1);

    // Rectangle fields are frozen at grant even if req_x changes mid-walk
    set_rect(0, 22, 50, 3, 1, 3'b110);
    bus.req = 3'b001;
    run_rect(0, 22, 50, 3, 1, 3'b110, 8, 1'b1, 1'b1);

    // Fresh reset, then three held requests served 0,1,2,0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_rect(0, 30, 10, 1, 0, 3'b001);
    set_rect(1, 40, 11, 1, 0, 3'b010);
    set_rect(2, 50, 12, 1, 0, 3'b111);
    bus.req = 3'b111;
    run_rect(0, 30, 10, 1, 0, 3'b001, 2, 1'b0, 1'b0);
    run_rect(1, 40, 11, 1, 0, 3'b010, 2, 1'b0, 1'b0);
    run_rect(2, 50, 12, 1, 0, 3'b111, 2, 1'b0, 1'b0);
    run_rect(0, 30, 10, 1, 0, 3'b001, 2, 1'b0, 1'b1);
    bus.req = '0;
    tick();
    check("final_busy", 32'(bus.busy), 0);
    check("final_grant", 32'(bus.grant), 0);
    check("final_done", 32'(bus.done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
